// File: rtl/phy_clk_gate_ctrl_if.sv
// Control/status bundle between a gated PHY sub-domain and its clock-gate enable controller.
// master = sub-domain/software side, slave = the controller.
interface phy_clk_gate_ctrl_if #(
    parameter int unsigned EVT_W = 16
);
    logic             busy;
    logic             wake_req;
    logic             sleep_allow;
    logic             force_on;
    logic             clk_en;
    logic             clk_active;
    logic             wake_ack;
    logic [EVT_W-1:0] off_events;

    modport master (
        output busy, wake_req, sleep_allow, force_on,
        input  clk_en, clk_active, wake_ack, off_events
    );

    modport slave (
        input  busy, wake_req, sleep_allow, force_on,
        output clk_en, clk_active, wake_ack, off_events
    );
endinterface

// File: rtl/phy_clk_gate_ctrl.sv
// Generates the clk_en input of a PHY latch-based clock gate: gates after an idle
// hysteresis, re-enables on demand and acknowledges once the wake settle delay expires.
module phy_clk_gate_ctrl #(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned EVT_W       = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    phy_clk_gate_ctrl_if.slave   bus
);

    localparam int unsigned IDLE_LAST = IDLE_CYCLES - 1;
    localparam int unsigned WAKE_LAST = WAKE_CYCLES - 1;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_OFF       = 2'd2,
        ST_WAKE      = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clk_en_q, clk_en_d;
    logic               clk_active_q, clk_active_d;
    logic               wake_ack_q, wake_ack_d;
    logic [EVT_W-1:0]   off_events_q, off_events_d;
    logic               idle_c;

    assign idle_c = bus.sleep_allow & ~bus.busy & ~bus.wake_req & ~bus.force_on;

    // State and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            clk_en_q     <= 1'b1;
            clk_active_q <= 1'b1;
            wake_ack_q   <= 1'b0;
            off_events_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_en_q     <= clk_en_d;
            clk_active_q <= clk_active_d;
            wake_ack_q   <= wake_ack_d;
            off_events_q <= off_events_d;
        end
    end

    // Next state; outputs follow the next state so they change on the transition edge
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wake_ack_d   = 1'b0;
        off_events_d = off_events_q;

        unique case (state_q)
            ST_RUN: begin
                if (idle_c) begin
                    state_d = ST_IDLE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_IDLE_WAIT: begin
                // A dropping idle beats the final hysteresis count
                if (!idle_c) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(IDLE_LAST)) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    if (off_events_q != {EVT_W{1'b1}}) begin
                        off_events_d = off_events_q + EVT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (!idle_c) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                end
            end
            ST_WAKE: begin
                // Inputs ignored: a started wake always runs to completion
                if (cnt_q == CNT_W'(WAKE_LAST)) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    wake_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        clk_en_d     = (state_d != ST_OFF);
        clk_active_d = (state_d == ST_RUN) || (state_d == ST_IDLE_WAIT);
    end

    assign bus.clk_en     = clk_en_q;
    assign bus.clk_active = clk_active_q;
    assign bus.wake_ack   = wake_ack_q;
    assign bus.off_events = off_events_q;

endmodule

// File: tb/tb_phy_clk_gate_ctrl.sv
// Directed bench for phy_clk_gate_ctrl: hysteresis, abort, wake, overrides,
// off_events saturation (EVT_W=4) and asynchronous reset in the middle of a wake.
module tb_phy_clk_gate_ctrl;

    localparam int unsigned EVT_W = 4;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk_in = ~clk_in;

    phy_clk_gate_ctrl_if #(.EVT_W(EVT_W)) bus ();

    phy_clk_gate_ctrl #(
        .IDLE_CYCLES (16),
        .WAKE_CYCLES (2),
        .CNT_W       (8),
        .EVT_W       (EVT_W)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // From RUN with idle held: clk_en falls on the 17th edge (first idle sample + 16)
    task automatic go_off(input int exp_evt);
        repeat (16) step();
        check("pre_off_clk_en", 32'(bus.clk_en), 1);
        step();
        check("off_clk_en", 32'(bus.clk_en), 0);
        check("off_clk_active", 32'(bus.clk_active), 0);
        check("off_events", 32'(bus.off_events), 32'(exp_evt));
    endtask

    // From OFF: one-cycle wake_req pulse, idle returns during WAKE and is ignored
    task automatic pulse_wake();
        bus.wake_req = 1'b1;
        step();
        check("wake_clk_en", 32'(bus.clk_en), 1);
        check("wake_active0", 32'(bus.clk_active), 0);
        check("wake_ack_early", 32'(bus.wake_ack), 0);
        bus.wake_req = 1'b0;
        step();
        check("wake_ack_w1", 32'(bus.wake_ack), 0);
        step();
        check("wake_ack", 32'(bus.wake_ack), 1);
        check("wake_active1", 32'(bus.clk_active), 1);
    endtask

    initial begin
        bus.busy        = 1'b0;
        bus.wake_req    = 1'b0;
        bus.sleep_allow = 1'b0;
        bus.force_on    = 1'b0;

        // Reset values
        step();
        step();
        check("rst_clk_en", 32'(bus.clk_en), 1);
        check("rst_clk_active", 32'(bus.clk_active), 1);
        check("rst_wake_ack", 32'(bus.wake_ack), 0);
        check("rst_off_events", 32'(bus.off_events), 0);
        rst_n = 1'b1;

        // Hysteresis
        bus.sleep_allow = 1'b1;
        go_off(1);

        // Wake by wake_req pulse; no second ack
        pulse_wake();
        bus.sleep_allow = 1'b0;
        repeat (3) begin
            step();
            check("no_second_ack", 32'(bus.wake_ack), 0);
            check("run_clk_en", 32'(bus.clk_en), 1);
        end

        // Abort: idle for 15 samples, busy on the 16th
        bus.sleep_allow = 1'b1;
        repeat (15) step();
        bus.busy = 1'b1;
        step();
        check("abort15_clk_en", 32'(bus.clk_en), 1);
        check("abort15_active", 32'(bus.clk_active), 1);
        // Abort on the final hysteresis edge: idle drop wins
        bus.busy = 1'b0;
        repeat (16) step();
        bus.busy = 1'b1;
        step();
        check("abort16_clk_en", 32'(bus.clk_en), 1);
        check("abort16_events", 32'(bus.off_events), 0 + 1);
        bus.busy = 1'b0;
        go_off(2);

        // force_on wakes like wake_req
        bus.force_on = 1'b1;
        step();
        check("force_clk_en", 32'(bus.clk_en), 1);
        check("force_active0", 32'(bus.clk_active), 0);
        step();
        check("force_ack_w1", 32'(bus.wake_ack), 0);
        step();
        check("force_ack", 32'(bus.wake_ack), 1);
        check("force_active1", 32'(bus.clk_active), 1);
        // sleep_allow=0 keeps the clock on indefinitely
        bus.force_on    = 1'b0;
        bus.sleep_allow = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            check("hold_on_clk_en", 32'(bus.clk_en), 1);
        end
        check("hold_on_events", 32'(bus.off_events), 2);
        check("hold_on_ack", 32'(bus.wake_ack), 0);

        // Saturation: 20 off/on cycles on a 4-bit counter starting at 2
        bus.sleep_allow = 1'b1;
        for (int i = 0; i < 20; i++) begin
            go_off((2 + i + 1 > 15) ? 15 : 2 + i + 1);
            pulse_wake();
        end

        // Reset during WAKE with counter=1
        go_off(15);
        bus.wake_req = 1'b1;
        step();
        bus.wake_req = 1'b0;
        step();
        check("pre_rst_active", 32'(bus.clk_active), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clk_en", 32'(bus.clk_en), 1);
        check("arst_active", 32'(bus.clk_active), 1);
        check("arst_wake_ack", 32'(bus.wake_ack), 0);
        check("arst_events", 32'(bus.off_events), 0);
        bus.sleep_allow = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_no_ack", 32'(bus.wake_ack), 0);
            check("post_rst_active", 32'(bus.clk_active), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
